t5_lsu: RTL and testbench

- Memory-stage load/store unit; sits directly after the execute stage.
- Consumes execute outputs: opcode, funct3, effective address and store data that is already lane-replicated.
- Drives a single-master Wishbone-style data bus and returns aligned, sign/zero-extended load data.
- Asserts a stall while a bus transaction is outstanding.

---
 rtl/t5_pkg.sv | 10 +
 rtl/t5_lsu_align.sv | 20 ++
 rtl/t5_lsu.sv | 99 +++++++++
 tb/tb_t5_lsu.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/t5_pkg.sv
// t5_pkg: shared constants for the t5 memory stage: datapath width, load/store opcodes, access size codes and LSU state encoding
package t5_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] OPC_LOAD = 5'b00000;
  localparam logic [4:0] OPC_STORE = 5'b01000;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} lsu_state_e;
endpackage

// File: rtl/t5_lsu_align.sv
// t5_lsu_align: byte-lane select and load extract/extend; adr_i low address bits, size_i size code, uns_i zero-extend, rdat_i bus word -> sel_o lanes, ldat_o aligned result
module t5_lsu_align
  import t5_pkg::*;
(
  input  logic [1:0]      adr_i,
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  input  logic [XLEN-1:0] rdat_i,
  output logic [3:0]      sel_o,
  output logic [XLEN-1:0] ldat_o
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    sel_o = size_i == SZ_B ? 4'b0001 << adr_i : size_i == SZ_H ? 4'b0011 << {adr_i[1], 1'b0} : 4'b1111;
    b = rdat_i[{adr_i, 3'b000} +: 8];
    h = adr_i[1] ? rdat_i[31:16] : rdat_i[15:0];
    ldat_o = size_i == SZ_B ? {{24{~uns_i & b[7]}}, b} : size_i == SZ_H ? {{16{~uns_i & h[15]}}, h} : rdat_i;
  end
endmodule

// File: rtl/t5_lsu.sv
// t5_lsu: memory-stage LSU (sclk, srst async active-low, sena/xopc/xfn3/xadr/xdat in, dwb_* Wishbone master, mdat/mstall/mexc/mbad out); T5_LSU_MISALIGN_EN traps misaligned accesses
module t5_lsu
  import t5_pkg::*;
(
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic [4:0]      xopc,
  input  logic [2:0]      xfn3,
  input  logic [XLEN-1:0] xadr,
  input  logic [XLEN-1:0] xdat,
  output logic [XLEN-1:0] dwb_adr_o,
  output logic [XLEN-1:0] dwb_dat_o,
  output logic [3:0]      dwb_sel_o,
  output logic            dwb_we_o,
  output logic            dwb_stb_o,
  output logic            dwb_cyc_o,
  input  logic [XLEN-1:0] dwb_dat_i,
  input  logic            dwb_ack_i,
  output logic [XLEN-1:0] mdat,
  output logic            mstall,
  output logic            mexc,
  output logic [XLEN-1:0] mbad
);
  lsu_state_e state_q, state_d;
  logic [XLEN-1:2] adr_q;
  logic [XLEN-1:0] dat_q, mdat_q, ldat;
  logic [1:0] lo_q, size_q;
  logic [3:0] sel;
  logic we_q, uns_q, busy, acc, mis, issue, done;
  assign acc = sena && (xopc == OPC_LOAD || xopc == OPC_STORE);
  assign busy = state_q == BUSY;
  always_comb begin
    issue = !busy && acc && !mis;
    done = busy && dwb_ack_i;
    state_d = issue ? BUSY : done ? IDLE : state_q;
  end
  always_ff @(posedge sclk or negedge srst)
    if (!srst) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      adr_q <= '0;
      dat_q <= '0;
      lo_q <= '0;
      size_q <= '0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      mdat_q <= '0;
    end else begin
      if (issue) begin
        adr_q <= xadr[XLEN-1:2];
        dat_q <= xdat;
        lo_q <= xadr[1:0];
        size_q <= xfn3[13-12+1:0];
        we_q <= xopc == OPC_STORE;
        uns_q <= xfn3[2];
      end
      if (done && !we_q) mdat_q <= ldat;
    end
  end
  t5_lsu_align u_align (
    .adr_i (lo_q),
    .size_i(size_q),
    .uns_i (uns_q),
    .rdat_i(dwb_dat_i),
    .sel_o (sel),
    .ldat_o(ldat)
  );
  assign dwb_adr_o = busy ? {adr_q, 2'b00} : '0;
  assign dwb_dat_o = busy ? dat_q : '0;
  assign dwb_sel_o = busy ? sel : 4'b0000;
  assign dwb_we_o = busy && we_q;
  assign dwb_stb_o = busy;
  assign dwb_cyc_o = busy;
  assign mstall = busy;
  assign mdat = mdat_q;
`ifdef T5_LSU_MISALIGN_EN
  logic mexc_q, bad;
  logic [XLEN-1:0] mbad_q;
  assign mis = xfn3[1] ? |xadr[1:0] : xfn3[0] & xadr[0];
  assign bad = !busy && acc && mis;
  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      mexc_q <= 1'b0;
      mbad_q <= '0;
    end else begin
      mexc_q <= bad;
      if (bad) mbad_q <= xadr;
    end
  end
  assign mexc = mexc_q;
  assign mbad = mbad_q;
`else
  assign mis = 1'b0;
  assign mexc = 1'b0;
  assign mbad = '0;
`endif
endmodule

// File: tb/tb_t5_lsu.sv
// tb_t5_lsu: randomized self-checking bench for t5_lsu against an arithmetic reference model
module tb_t5_lsu;
  import t5_pkg::*;
  logic sclk = 1'b0, srst = 1'b0, sena = 1'b0, dwb_ack_i = 1'b0;
  logic [4:0] xopc = 5'b01100;
  logic [2:0] xfn3 = 3'b000;
  logic [31:0] xadr = '0, xdat = '0, dwb_dat_i = '0;
  logic [31:0] dwb_adr_o, dwb_dat_o, mdat, mbad;
  logic [3:0] dwb_sel_o;
  logic dwb_we_o, dwb_stb_o, dwb_cyc_o, mstall, mexc;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mdat_m = '0, mbad_m = '0;
  always #5 sclk = ~sclk;
  t5_lsu dut (
    .sclk(sclk), .srst(srst), .sena(sena), .xopc(xopc), .xfn3(xfn3), .xadr(xadr), .xdat(xdat),
    .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o), .dwb_sel_o(dwb_sel_o), .dwb_we_o(dwb_we_o),
    .dwb_stb_o(dwb_stb_o), .dwb_cyc_o(dwb_cyc_o), .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i),
    .mdat(mdat), .mstall(mstall), .mexc(mexc), .mbad(mbad)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] ref_sel(input logic [2:0] f3, input logic [31:0] a);
    int unsigned k;
    k = a % 4;
    if (f3[1:0] == 2'b00) return 4'((1 << k) & 15);
    if (f3[1:0] == 2'b01) return k >= 2 ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int unsigned v;
    if (f3[1:0] == 2'b00) begin
      v = (rd / (32'd1 << (8 * (a % 4)))) % 256;
      if (!f3[2] && v >= 128) v = v + 32'hFFFFFF00;
    end else if (f3[1:0] == 2'b01) begin
      v = (rd / (32'd1 << (16 * ((a % 4) / 2)))) % 65536;
      if (!f3[2] && v >= 32768) v = v + 32'hFFFF0000;
    end else v = rd;
    return v;
  endfunction
`ifdef T5_LSU_MISALIGN_EN
  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1]) return a % 4 != 0;
    return f3[0] && a % 2 != 0;
  endfunction
`endif
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int w);
    @(negedge sclk);
    sena = 1'b1; xopc = st ? OPC_STORE : OPC_LOAD; xfn3 = f3; xadr = a; xdat = d;
    @(negedge sclk);
    sena = 1'b0; xopc = 5'b01100; xadr = $urandom; xdat = $urandom;
`ifdef T5_LSU_MISALIGN_EN
    if (is_mis(f3, a)) begin
      mbad_m = a;
      check("mis_cyc", dwb_cyc_o, 0);
      check("mis_stall", mstall, 0);
      check("mis_exc", mexc, 1);
      check("mis_bad", mbad, mbad_m);
      @(negedge sclk);
      check("mis_pulse", mexc, 0);
      check("mis_mdat", mdat, mdat_m);
      return;
    end
`endif
    for (int i = 0; i <= w; i++) begin
      check("stall", mstall, 1);
      check("cyc_stb", {dwb_cyc_o, dwb_stb_o}, 2'b11);
      check("adr", dwb_adr_o, a - a % 4);
      check("sel", dwb_sel_o, ref_sel(f3, a));
      check("we", dwb_we_o, st);
      check("dat", dwb_dat_o, d);
      check("exc", mexc, 0);
      check("bad", mbad, mbad_m);
      if (i == w) begin
        dwb_ack_i = 1'b1;
        dwb_dat_i = rd;
      end
      @(negedge sclk);
    end
    dwb_ack_i = 1'b0;
    dwb_dat_i = $urandom;
    if (!st) mdat_m = ref_load(f3, a, rd);
    check("done_stall", mstall, 0);
    check("done_cyc", dwb_cyc_o, 0);
    check("done_sel", dwb_sel_o, 0);
    check("mdat", mdat, mdat_m);
  endtask
  initial begin
    #1;
    check("rst_cyc", {dwb_cyc_o, dwb_stb_o, dwb_we_o, mstall, mexc}, 0);
    check("rst_adr", dwb_adr_o, 0);
    check("rst_mdat", mdat, 0);
    check("rst_bad", mbad, 0);
    @(negedge sclk);
    srst = 1'b1;
    access(0, 3'b010, 32'h1004, 32'h0, 32'hDEADBEEF, 0);
    access(0, 3'b000, 32'h2003, 32'h0, 32'h80112233, 1);
    access(0, 3'b100, 32'h2003, 32'h0, 32'h80112233, 0);
    access(1, 3'b001, 32'h3002, 32'hABCDABCD, 32'h5555AAAA, 3);
    access(0, 3'b010, 32'h4001, 32'h0, 32'h12345678, 0);
    access(0, 3'b101, 32'h5002, 32'h0, 32'h9ABC0000, 2);
    @(negedge sclk);
    sena = 1'b1; xopc = 5'b01100; dwb_ack_i = 1'b1; dwb_dat_i = 32'hFFFFFFFF;
    @(negedge sclk);
    check("nonmem_bus", {dwb_cyc_o, dwb_stb_o, dwb_we_o, mstall, dwb_sel_o}, 0);
    check("nonmem_adr", dwb_adr_o | dwb_dat_o, 0);
    check("nonmem_mdat", mdat, mdat_m);
    sena = 1'b0; xopc = OPC_LOAD; dwb_ack_i = 1'b0;
    @(negedge sclk);
    check("sena_low", {dwb_cyc_o, mstall}, 0);
    xopc = 5'b01100;
    access(0, 3'b010, 32'h6000, 32'h0, 32'h0BADF00D, 0);
    @(negedge sclk);
    sena = 1'b1; xopc = OPC_LOAD; xfn3 = 3'b010; xadr = 32'h7000;
    @(negedge sclk);
    sena = 1'b0; xopc = 5'b01100;
    check("rst_pre_cyc", dwb_cyc_o, 1);
    @(negedge sclk);
    @(negedge sclk);
    #2 srst = 1'b0;
    #1;
    check("arst_cyc", {dwb_cyc_o, dwb_stb_o, mstall}, 0);
    check("arst_mdat", mdat, 0);
    mdat_m = '0;
    mbad_m = '0;
    @(negedge sclk);
    srst = 1'b1;
    dwb_ack_i = 1'b1; dwb_dat_i = 32'h13572468;
    @(negedge sclk);
    dwb_ack_i = 1'b0;
    check("stray_ack_cyc", {dwb_cyc_o, mstall}, 0);
    check("stray_ack_mdat", mdat, 0);
    for (int n = 0; n < 300; n++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      access(1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
